// File: rtl/adder_tree_pkg.sv
// Shared types and sizing helpers for the pipelined synapse adder tree.
// Sums fan in one level at a time, and the accumulator widens the result into SW bits.
package adder_tree_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_e;

    function automatic int sum_width(input int w, input int n_stage, input int acc_bits);
        return w + n_stage + acc_bits;
    endfunction

    // Clamp bounds are returned 64 bits wide; callers keep the low sw bits.
    function automatic logic [63:0] sat_max(input int sw, input bit is_signed);
        return is_signed ? (64'd1 << (sw - 1)) - 64'd1 : (64'd1 << sw) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int sw, input bit is_signed);
        return is_signed ? ~((64'd1 << (sw - 1)) - 64'd1) : 64'd0;
    endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One registered tree level: each pair of IN_W-bit elements is extended and summed to IN_W+1 bits.
// Flags: valid/first/last move forward together; first/last are forced low when valid is 0.
module adder_tree_stage #(
    parameter int IN_W    = 2,
    parameter int N_PAIRS = 1,
    parameter bit SIGNED  = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic                          in_first,
    input  logic                          in_last,
    input  logic [2*N_PAIRS*IN_W-1:0]     in_data,
    output logic                          out_valid,
    output logic                          out_first,
    output logic                          out_last,
    output logic [N_PAIRS*(IN_W+1)-1:0]   out_data
);

    localparam int OUT_W = IN_W + 1;

    logic [N_PAIRS*OUT_W-1:0] sum_d;

    function automatic logic [OUT_W-1:0] ext(input logic [IN_W-1:0] x);
        return {(SIGNED ? x[IN_W-1] : 1'b0), x};
    endfunction

    for (genvar p = 0; p < N_PAIRS; p++) begin : g_pair
        assign sum_d[p*OUT_W +: OUT_W] = ext(in_data[2*p*IN_W +: IN_W])
                                       + ext(in_data[(2*p+1)*IN_W +: IN_W]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= in_valid;
            out_first <= in_valid & in_first;
            out_last  <= in_valid & in_last;
            out_data  <= sum_d;
        end
    end

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined synapse adder tree followed by a saturating beat accumulator.
// Handshake: a beat is accepted whenever in_valid is 1 (there is no backpressure); sum_valid pulses once per group.
module pipelined_adder_tree
    import adder_tree_pkg::*;
#(
    parameter int  N_STAGE  = 6,
    parameter int  W        = 2,
    parameter bit  SIGNED   = 1'b1,
    parameter int  ACC_BITS = 4,
    localparam int N_IN     = 2**N_STAGE,
    localparam int SW       = sum_width(W, N_STAGE, ACC_BITS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_first,
    input  logic              in_last,
    input  logic [N_IN*W-1:0] wx,
    output logic [SW-1:0]     sum_out,
    output logic              sum_valid,
    output logic              sat,
    output logic              proto_err,
    output acc_state_e        acc_state
);

    localparam int TW = W + N_STAGE;
    localparam logic [63:0] SAT_MAX64 = sat_max(SW, SIGNED);
    localparam logic [63:0] SAT_MIN64 = sat_min(SW, SIGNED);
    localparam logic [SW-1:0] SAT_MAX = SAT_MAX64[SW-1:0];
    localparam logic [SW-1:0] SAT_MIN = SAT_MIN64[SW-1:0];

    // All tree levels are packed into one flat bus. Level 0 is the registered input.
    function automatic int lvl_off(input int lvl);
        int o = 0;
        for (int j = 0; j < lvl; j++) o += (N_IN >> j) * (W + j);
        return o;
    endfunction

    localparam int TREE_BITS = lvl_off(N_STAGE + 1);
    localparam int TOP_OFF   = lvl_off(N_STAGE);

    logic [TREE_BITS-1:0] tree_data;
    logic [N_STAGE:0]     lvl_valid, lvl_first, lvl_last;
    logic [N_IN*W-1:0]    wx_q;
    logic                 valid_q, first_q, last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wx_q    <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            wx_q    <= wx;
            valid_q <= in_valid;
            first_q <= in_valid & in_first;
            last_q  <= in_valid & in_last;
        end
    end

    assign tree_data[N_IN*W-1:0] = wx_q;
    assign lvl_valid[0] = valid_q;
    assign lvl_first[0] = first_q;
    assign lvl_last[0]  = last_q;

    for (genvar i = 1; i <= N_STAGE; i++) begin : g_stage
        localparam int IN_W    = W + i - 1;
        localparam int N_PAIRS = N_IN >> i;
        adder_tree_stage #(
            .IN_W    (IN_W),
            .N_PAIRS (N_PAIRS),
            .SIGNED  (SIGNED)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (lvl_valid[i-1]),
            .in_first  (lvl_first[i-1]),
            .in_last   (lvl_last[i-1]),
            .in_data   (tree_data[lvl_off(i-1) +: 2*N_PAIRS*IN_W]),
            .out_valid (lvl_valid[i]),
            .out_first (lvl_first[i]),
            .out_last  (lvl_last[i]),
            .out_data  (tree_data[lvl_off(i) +: N_PAIRS*(IN_W+1)])
        );
    end

    logic [TW-1:0] tree_sum;
    logic          tv, tf, tl;

    assign tree_sum = tree_data[TOP_OFF +: TW];
    assign tv = lvl_valid[N_STAGE];
    assign tf = lvl_first[N_STAGE];
    assign tl = lvl_last[N_STAGE];

    acc_state_e    state_q, state_d;
    logic [SW-1:0] acc_q, acc_d, sum_d, clamped;
    logic          sticky_q, sticky_d, valid_d, sat_d, perr_d, restart, ovf;
    logic [SW:0]   tree_ext, acc_ext, raw;

    // The add is one bit wider than SW, so a carry out or sign change shows up as overflow.
    assign tree_ext = SIGNED ? {{(SW+1-TW){tree_sum[TW-1]}}, tree_sum}
                             : {{(SW+1-TW){1'b0}}, tree_sum};
    assign acc_ext  = {(SIGNED ? acc_q[SW-1] : 1'b0), acc_q};
    assign restart  = tf || (state_q == IDLE);
    assign raw      = (restart ? '0 : acc_ext) + tree_ext;
    assign ovf      = SIGNED ? (raw[SW] != raw[SW-1]) : raw[SW];
    assign clamped  = !ovf ? raw[SW-1:0] : ((SIGNED && raw[SW]) ? SAT_MIN : SAT_MAX);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        sticky_d = sticky_q;
        sum_d    = sum_out;
        sat_d    = sat;
        valid_d  = 1'b0;
        perr_d   = 1'b0;
        if (tv) begin
            perr_d   = ((state_q == IDLE) && !tf) || ((state_q == ACCUM) && tf);
            acc_d    = clamped;
            sticky_d = (restart ? 1'b0 : sticky_q) | ovf;
            if (tl) begin
                valid_d = 1'b1;
                sum_d   = clamped;
                sat_d   = (restart ? 1'b0 : sticky_q) | ovf;
                state_d = IDLE;
            end else begin
                state_d = ACCUM;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            sticky_q  <= 1'b0;
            sum_out   <= '0;
            sum_valid <= 1'b0;
            sat       <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            sticky_q  <= sticky_d;
            sum_out   <= sum_d;
            sum_valid <= valid_d;
            sat       <= sat_d;
            proto_err <= perr_d;
        end
    end

    assign acc_state = state_q;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Bench for pipelined_adder_tree: a signed and an unsigned instance get the same beats.
// Every cycle has an expected output record, which is checked LAT cycles after the beat is driven.
module tb_pipelined_adder_tree;
    import adder_tree_pkg::*;

    localparam int N_STAGE  = 6;
    localparam int W        = 2;
    localparam int ACC_BITS = 4;
    localparam int N_IN     = 2**N_STAGE;
    localparam int SW       = W + N_STAGE + ACC_BITS;
    localparam int WX       = N_IN * W;
    localparam int LAT      = N_STAGE + 1;

    typedef logic [SW-1:0] sw_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
    logic [WX-1:0] wx = '0;

    sw_t        s_sum, u_sum;
    logic       s_valid, u_valid, s_sat, u_sat, s_perr, u_perr;
    acc_state_e s_state, u_state;

    pipelined_adder_tree #(.N_STAGE(N_STAGE), .W(W), .SIGNED(1'b1), .ACC_BITS(ACC_BITS)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .wx(wx), .sum_out(s_sum), .sum_valid(s_valid), .sat(s_sat), .proto_err(s_perr),
        .acc_state(s_state)
    );

    pipelined_adder_tree #(.N_STAGE(N_STAGE), .W(W), .SIGNED(1'b0), .ACC_BITS(ACC_BITS)) dut_u (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .wx(wx), .sum_out(u_sum), .sum_valid(u_valid), .sat(u_sat), .proto_err(u_perr),
        .acc_state(u_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic v;
        sw_t  s_sum;
        logic s_sat;
        sw_t  u_sum;
        logic u_sat;
        logic perr;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    sw_t  held_s = '0, held_u = '0;

    typedef struct {
        int       beats;
        logic [1:0] elem;
        int       gap;
        int       s_exp;
        logic     s_sat;
        int       u_exp;
        logic     u_sat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input exp_t e);
        chk("s_valid", 32'(s_valid), 32'(e.v));
        chk("u_valid", 32'(u_valid), 32'(e.v));
        chk("s_sum", 32'(s_sum), 32'(e.s_sum));
        chk("u_sum", 32'(u_sum), 32'(e.u_sum));
        chk("s_perr", 32'(s_perr), 32'(e.perr));
        chk("u_perr", 32'(u_perr), 32'(e.perr));
        if (e.v) begin
            chk("s_sat", 32'(s_sat), 32'(e.s_sat));
            chk("u_sat", 32'(u_sat), 32'(e.u_sat));
        end
    endtask

    function automatic exp_t idle_rec(input logic perr);
        exp_t e;
        e = '{1'b0, held_s, 1'b0, held_u, 1'b0, perr};
        return e;
    endfunction

    function automatic exp_t result_rec(input int s_exp, input logic s_sat_e,
                                        input int u_exp, input logic u_sat_e);
        exp_t e;
        held_s = sw_t'(s_exp);
        held_u = sw_t'(u_exp);
        e = '{1'b1, held_s, s_sat_e, held_u, u_sat_e, 1'b0};
        return e;
    endfunction

    function automatic logic [WX-1:0] fill(input logic [1:0] el);
        logic [WX-1:0] d;
        for (int k = 0; k < N_IN; k++) d[k*W +: W] = el;
        return d;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input logic v, input logic f, input logic l,
                        input logic [WX-1:0] d, input exp_t e);
        exp_t got;
        in_valid = v;
        in_first = f;
        in_last  = l;
        wx       = d;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == LAT + 1) begin
            got = exp_q.pop_front();
            check_outputs(got);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, idle_rec(1'b0));
    endtask

    task automatic run_group(input int beats, input logic [1:0] el, input int s_exp,
                             input logic s_sat_e, input int u_exp, input logic u_sat_e);
        for (int b = 0; b < beats; b++) begin
            if (b == beats - 1)
                step(1'b1, b == 0, 1'b1, fill(el), result_rec(s_exp, s_sat_e, u_exp, u_sat_e));
            else
                step(1'b1, b == 0, 1'b0, fill(el), idle_rec(1'b0));
        end
    endtask

    task automatic run_random_group(input int beats);
        logic [WX-1:0] d;
        logic [1:0]    el;
        int            s_acc, u_acc;
        s_acc = 0;
        u_acc = 0;
        for (int b = 0; b < beats; b++) begin
            for (int k = 0; k < WX / 32; k++) d[k*32 +: 32] = $urandom;
            for (int k = 0; k < N_IN; k++) begin
                el = d[k*W +: W];
                u_acc += int'(el);
                s_acc += el[1] ? int'(el) - 4 : int'(el);
            end
            if (b == beats - 1)
                step(1'b1, b == 0, 1'b1, d, result_rec(s_acc, 1'b0, u_acc, 1'b0));
            else
                step(1'b1, b == 0, 1'b0, d, idle_rec(1'b0));
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        #1;
        chk("rst_s_sum", 32'(s_sum), 32'd0);
        chk("rst_u_sum", 32'(u_sum), 32'd0);
        chk("rst_valid", 32'({s_valid, u_valid}), 32'd0);
        chk("rst_sat", 32'({s_sat, u_sat}), 32'd0);
        chk("rst_perr", 32'({s_perr, u_perr}), 32'd0);
        chk("rst_state", 32'(s_state), 32'(IDLE));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        held_s = '0;
        held_u = '0;
        for (int i = 0; i < LAT; i++) exp_q.push_back(idle_rec(1'b0));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0] = '{1,  2'b01, 2, 64,    1'b0, 64,   1'b0};
        vecs[1] = '{1,  2'b11, 0, -64,   1'b0, 192,  1'b0};
        vecs[2] = '{4,  2'b01, 0, 256,   1'b0, 256,  1'b0};
        vecs[3] = '{1,  2'b11, 3, -64,   1'b0, 192,  1'b0};
        vecs[4] = '{33, 2'b01, 0, 2047,  1'b1, 2112, 1'b0};
        vecs[5] = '{1,  2'b00, 2, 0,     1'b0, 0,    1'b0};
        vecs[6] = '{1,  2'b10, 1, -128,  1'b0, 128,  1'b0};
        vecs[7] = '{40, 2'b11, 1, -2048, 1'b1, 4095, 1'b1};
        vecs[8] = '{22, 2'b11, 0, -1408, 1'b0, 4095, 1'b1};
        vecs[9] = '{21, 2'b11, 2, -1344, 1'b0, 4032, 1'b0};

        do_reset();
        idle(2);

        for (int i = 0; i < 10; i++) begin
            run_group(vecs[i].beats, vecs[i].elem, vecs[i].s_exp, vecs[i].s_sat,
                      vecs[i].u_exp, vecs[i].u_sat);
            idle(vecs[i].gap);
        end

        // Beat without first while IDLE: flagged, still counted as the start of a group.
        step(1'b1, 1'b0, 1'b0, fill(2'b01), idle_rec(1'b1));
        step(1'b1, 1'b0, 1'b1, fill(2'b01), result_rec(128, 1'b0, 128, 1'b0));
        idle(1);

        // A first in mid-group drops the partial sum; only the last two beats count.
        step(1'b1, 1'b1, 1'b0, fill(2'b01), idle_rec(1'b0));
        step(1'b1, 1'b0, 1'b0, fill(2'b01), idle_rec(1'b0));
        step(1'b1, 1'b1, 1'b0, fill(2'b11), idle_rec(1'b1));
        step(1'b1, 1'b0, 1'b1, fill(2'b11), result_rec(-128, 1'b0, 384, 1'b0));
        idle(LAT + 1);

        for (int g = 0; g < 3; g++) begin
            run_random_group($urandom_range(1, 5));
            idle($urandom_range(0, 2));
        end
        idle(LAT + 1);

        // Reset while three beats of a group are still in the pipeline.
        step(1'b1, 1'b1, 1'b0, fill(2'b01), idle_rec(1'b0));
        step(1'b1, 1'b0, 1'b0, fill(2'b01), idle_rec(1'b0));
        step(1'b1, 1'b0, 1'b0, fill(2'b01), idle_rec(1'b0));
        do_reset();
        idle(12);
        run_group(2, 2'b01, 128, 1'b0, 128, 1'b0);
        idle(LAT + 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipelined_adder_tree.md
# pipelined_adder_tree

Parametrised, pipelined successor to the combinational synapse adder tree. It reduces 2**N_STAGE signed (or unsigned) W-bit weight·input products to one sum, registering every tree level. A trailing accumulator sums consecutive input beats (time-multiplexed synapse chunks), so one neuron can take more inputs than the tree is wide. It sits between the weight/spike product array and the LIF membrane-potential update.

## Interface
- N_STAGE, 6: tree levels; N_IN = 2**N_STAGE elements per beat (minimum 1)
- W, 2: element width in bits
- SIGNED, 1: 1 = two's-complement elements, sign-extended; 0 = unsigned, zero-extended
- ACC_BITS, 4: extra accumulator headroom bits; SW = W+N_STAGE+ACC_BITS
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  beat present on wx this cycle
- in_first  in  1  beat starts a new accumulation
- in_last  in  1  beat ends the accumulation; result is emitted
- wx  in  N_IN*W  element k at wx[k*W +: W]
- sum_out  out  SW  accumulated sum, held between results
- sum_valid  out  1  one-cycle pulse, sum_out is new
- sat  out  1  accumulation saturated; valid with sum_valid
- proto_err  out  1  one-cycle pulse on first/last protocol violation

## Operation
- No backpressure: one beat per cycle is accepted at full rate; in_first/in_last are ignored when in_valid=0.
- Tree level i (1..N_STAGE) adds pairs from level i-1 at width W+i, with extension per SIGNED. It is exact and never overflows.
- first, last, and valid travel alongside the data in a shift pipeline.
- Accumulator states: IDLE, ACCUM.
  - Tree beat with first: acc = tree_sum, extended to SW.
  - Tree beat without first: acc = acc + tree_sum.
  - Beat with last: emit, go to IDLE. Otherwise go to ACCUM.
- Protocol violations:
  - Beat without first in IDLE: treated as first and proto_err pulses.
  - First arriving in ACCUM: partial discarded, restarts, and proto_err pulses.
  - first and last on the same beat: legal single-beat result.
- Saturation:
  - The accumulator add clamps to [-(2**(SW-1)), 2**(SW-1)-1] when SIGNED, else [0, 2**SW-1].
  - Any clamp during an accumulation sets a sticky flag. It is cleared at first and output as sat with the result.
- Reset values:
  - sum_out=0, sum_valid=0, sat=0, proto_err=0.
  - All pipeline valids 0, acc 0, state IDLE.
- Reset mid-operation discards all in-flight beats and the partial accumulation, with no spurious sum_valid after release.

## Timing
- Tree latency is N_STAGE cycles. The accumulator register adds 1, so an in_last beat sampled at edge n gives sum_valid high after edge n+N_STAGE+1.
- Throughput is 1 beat/cycle. Back-to-back accumulations are legal: a last beat followed immediately by a first beat yields results one cycle apart for single-beat groups.
- proto_err is aligned with the accumulator update of the offending beat, at the same latency as sum_valid.
- sum_out is updated only on sum_valid cycles.

## Structure
- Package adder_tree_pkg:
  - Function for SW.
  - Saturation min/max constant functions of SW/SIGNED.
  - Accumulator state enum {IDLE, ACCUM}.
- Sub-module adder_tree_stage (parameters IN_W, N_PAIRS, SIGNED): one level of pairwise extend-and-add plus the output register and valid/first/last flags. It is instantiated N_STAGE times in a generate loop.
- The top level holds the generate loop and the accumulator FSM.

## Test plan
- Defaults; one beat, all elements 2'b01, first=last=1 -> sum_out=64, sat=0, sum_valid exactly 7 cycles later.
- All elements 2'b11, SIGNED=1 -> -64; same stimulus with SIGNED=0 -> 192.
- 4 beats of all-01, first on beat 0, last on beat 3, back-to-back -> single sum_valid with 256. Immediately followed by a 1-beat group of all-11 -> -64 on the very next cycle.
- 33 beats of all-01 (2112 > 2047) -> sum_out=2047, sat=1. The next group, one beat of all-00 -> 0, sat=0.
- Protocol errors:
  - A beat without first while IDLE -> proto_err pulse and a correct result.
  - first mid-group -> proto_err, and the result counts only beats from the second first.
- reset asserted for 1 cycle while 3 beats are in flight -> outputs 0 immediately, no sum_valid afterwards. A new group then works normally.
